// File: rtl/cnn_relu_stream.sv
// cnn_relu_stream: per-channel activation, rounding requantisation and saturation in a 2-stage pipeline.
// Define CNN_RELU_STATS_EN to add the stats_clr input and the zero_cnt activation-zero counter.
module cnn_relu_stream #(
    parameter int N_CH  = 64,
    parameter int IN_W  = 48,
    parameter int OUT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*IN_W-1:0]  in_data,
    input  logic [1:0]            mode,
    input  logic [5:0]            shift,
    input  logic [IN_W-1:0]       clip_max,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*OUT_W-1:0] out_data,
    output logic [N_CH-1:0]       out_sat
`ifdef CNN_RELU_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [31:0]           zero_cnt
`endif
);

    localparam logic signed [IN_W:0] SAT_MAX   = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN   = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [IN_W:0] RND_ONE   = {{IN_W{1'b0}}, 1'b1};
    localparam logic [5:0]           SHIFT_LIM = 6'(IN_W - 1);

    function automatic logic signed [IN_W-1:0] act_fn(input logic signed [IN_W-1:0] x,
                                                      input logic [1:0]             m,
                                                      input logic signed [IN_W-1:0] c);
        logic signed [IN_W-1:0] pos;
        pos = x[IN_W-1] ? '0 : x;
        case (m)
            2'd0:    act_fn = x;
            2'd1:    act_fn = pos;
            2'd2:    act_fn = x[IN_W-1] ? (x >>> 3) : x;
            default: act_fn = (pos > c) ? c : pos;
        endcase
    endfunction

    // One extra bit of headroom keeps the half-LSB bias from overflowing.
    function automatic logic signed [IN_W:0] rnd_fn(input logic signed [IN_W-1:0] y,
                                                    input logic [5:0]             sh);
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] bias;
        logic signed [IN_W:0] sum;
        ext  = {y[IN_W-1], y};
        bias = RND_ONE <<< (sh - 6'd1);
        sum  = ext + bias;
        rnd_fn = (sh == 6'd0) ? ext : (sum >>> sh);
    endfunction

    // Result MSB is the saturation flag, the rest is the signed OUT_W value.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [IN_W:0] r);
        if (r > SAT_MAX)
            sat_fn = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        else if (r < SAT_MIN)
            sat_fn = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else
            sat_fn = {1'b0, r[OUT_W-1:0]};
    endfunction

    logic                   vld_p1;
    logic                   vld_p2;
    logic                   s1_adv;
    logic                   s1_open;
    logic                   in_fire;
    logic signed [IN_W-1:0] cmax_p0;
    logic [5:0]             sh_p0;
    logic [N_CH*IN_W-1:0]   y_p0;
    logic [N_CH*IN_W-1:0]   y_p1;
    logic [5:0]             sh_p1;
    logic [N_CH*OUT_W-1:0]  q_p1;
    logic [N_CH-1:0]        qs_p1;

    assign s1_adv    = !vld_p2 || out_ready;
    assign s1_open   = !vld_p1 || s1_adv;
    assign in_ready  = !rst && s1_open;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = vld_p2 && !rst;

    // Stage p0: activation on the incoming beat
    assign cmax_p0 = clip_max[IN_W-1] ? '0 : $signed(clip_max);
    assign sh_p0   = (int'(shift) >= IN_W) ? SHIFT_LIM : shift;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_act
        assign y_p0[ch*IN_W +: IN_W] = act_fn(in_data[ch*IN_W +: IN_W], mode, cmax_p0);
    end

    // Stage p1: activation result and the beat's shift amount
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (s1_open)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            y_p1  <= y_p0;
            sh_p1 <= sh_p0;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_req
        logic [OUT_W:0] sq;
        assign sq                      = sat_fn(rnd_fn(y_p1[ch*IN_W +: IN_W], sh_p1));
        assign q_p1[ch*OUT_W +: OUT_W] = sq[OUT_W-1:0];
        assign qs_p1[ch]               = sq[OUT_W];
    end

    // Stage p2: requantised, saturated output beat
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
            out_sat  <= '0;
        end else if (s1_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_data <= q_p1;
                out_sat  <= qs_p1;
            end
        end
    end

`ifdef CNN_RELU_STATS_EN
    localparam int CW = $clog2(N_CH + 1);

    logic [N_CH-1:0] zero_p0;
    logic [CW-1:0]   nz_p0;
    logic [32:0]     cnt_sum;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_zero
        assign zero_p0[ch] = in_data[ch*IN_W + IN_W - 1] && (y_p0[ch*IN_W +: IN_W] == '0);
    end

    always_comb begin
        nz_p0 = '0;
        for (int i = 0; i < N_CH; i++)
            nz_p0 = nz_p0 + CW'(zero_p0[i]);
    end

    assign cnt_sum = {1'b0, zero_cnt} + 33'(nz_p0);

    always_ff @(posedge clk) begin
        if (rst || stats_clr)
            zero_cnt <= '0;
        else if (in_fire)
            zero_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_cnn_relu_stream.sv
// Directed bench for cnn_relu_stream (N_CH=4, IN_W=48, OUT_W=16) with hand-computed expectations.
module tb_cnn_relu_stream;

    localparam int N_CH  = 4;
    localparam int IN_W  = 48;
    localparam int OUT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_CH*IN_W-1:0]  in_data = '0;
    logic [1:0]            mode = 2'd0;
    logic [5:0]            shift = 6'd0;
    logic [IN_W-1:0]       clip_max = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [N_CH*OUT_W-1:0] out_data;
    logic [N_CH-1:0]       out_sat;
`ifdef CNN_RELU_STATS_EN
    logic                  stats_clr = 1'b0;
    logic [31:0]           zero_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;
    int sent;
    int rcvd;

    cnn_relu_stream #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .shift     (shift),
        .clip_max  (clip_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef CNN_RELU_STATS_EN
        ,
        .stats_clr (stats_clr),
        .zero_cnt  (zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [N_CH*IN_W-1:0] pk(input longint a, input longint b,
                                                 input longint c, input longint d);
        return {48'(d), 48'(c), 48'(b), 48'(a)};
    endfunction

    function automatic logic [N_CH*OUT_W-1:0] po(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Stream beat k, channel ch carries 10*k + 3*ch - 25; mode 1 keeps the positive part.
    function automatic logic [N_CH*IN_W-1:0] sbeat(input int k);
        return pk(10*k - 25, 10*k - 22, 10*k - 19, 10*k - 16);
    endfunction

    function automatic logic [N_CH*OUT_W-1:0] sexp(input int k);
        int v[4];
        for (int ch = 0; ch < 4; ch++) begin
            v[ch] = 10*k + 3*ch - 25;
            if (v[ch] < 0) v[ch] = 0;
        end
        return po(v[0], v[1], v[2], v[3]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat, then scrambles the sideband inputs so late sampling would be caught.
    task automatic one_beat(input string tag, input logic [N_CH*IN_W-1:0] d, input logic [1:0] m,
                            input logic [5:0] s, input longint c);
        in_data  = d;
        mode     = m;
        shift    = s;
        clip_max = 48'(c);
        in_valid = 1'b1;
        #1;
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        mode     = ~m;
        shift    = s + 6'd5;
        clip_max = '0;
        chk({tag, " lat1 out_valid"}, 64'(out_valid), 64'd0);
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_sat", 64'(out_sat), 64'd0);
`ifdef CNN_RELU_STATS_EN
        chk("rst zero_cnt", 64'(zero_cnt), 64'd0);
`endif
        rst = 1'b0;

        one_beat("relu", pk(-5, 7, 0, -1), 2'd1, 6'd0, 0);
        chk("relu out_valid", 64'(out_valid), 64'd1);
        chk("relu out_data", 64'(out_data), 64'(po(0, 7, 0, 0)));
        chk("relu out_sat", 64'(out_sat), 64'd0);
        tick();

        one_beat("leaky", pk(-64, -1, 8, 100000), 2'd2, 6'd0, 0);
        chk("leaky out_valid", 64'(out_valid), 64'd1);
        chk("leaky out_data", 64'(out_data), 64'(po(-8, -1, 8, 32767)));
        chk("leaky out_sat", 64'(out_sat), 64'b1000);
        tick();

        one_beat("clip", pk(-3, 49, 51, 200), 2'd3, 6'd1, 50);
        chk("clip out_data", 64'(out_data), 64'(po(0, 25, 25, 25)));
        chk("clip out_sat", 64'(out_sat), 64'd0);
        tick();

        one_beat("negclip", pk(5, -5, 0, 100), 2'd3, 6'd0, -10);
        chk("negclip out_data", 64'(out_data), 64'(po(0, 0, 0, 0)));
        tick();

        // Bypass with rounding on negatives and saturation in both directions
        one_beat("bypass", pk(-100, -8, 1073741824, -1073741824), 2'd0, 6'd4, 0);
        chk("bypass out_data", 64'(out_data), 64'(po(-6, 0, 32767, -32768)));
        chk("bypass out_sat", 64'(out_sat), 64'b1100);
        tick();

        // Shift 63 behaves as 47
        one_beat("shclamp", pk(64'h0000_4000_0000_0000, -1, 64'hFFFF_8000_0000_0000,
                               64'h0000_7FFF_FFFF_FFFF), 2'd0, 6'd63, 0);
        chk("shclamp out_data", 64'(out_data), 64'(po(1, 0, -1, 1)));
        chk("shclamp out_sat", 64'(out_sat), 64'd0);
        tick();

        // Ten back-to-back beats with downstream stalled on cycles 3..6
        sent = 0;
        rcvd = 0;
        mode = 2'd1;
        shift = 6'd0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 10);
            in_data   = sbeat(sent);
            #1;
            chk($sformatf("stream in_ready c%0d", cyc), 64'(in_ready), 64'(!(cyc >= 3 && cyc <= 6)));
            if (cyc >= 3 && cyc <= 6)
                chk($sformatf("stream hold valid c%0d", cyc), 64'(out_valid), 64'd1);
            if (out_valid) begin
                chk($sformatf("stream beat %0d", rcvd), 64'(out_data), 64'(sexp(rcvd)));
                if (out_ready) rcvd++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            if (rcvd == 10) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream delivered", 64'(rcvd), 64'd10);
        #1;
        chk("stream drained", 64'(out_valid), 64'd0);
        tick();

        // Reset with two beats in flight
        out_ready = 1'b0;
        mode      = 2'd1;
        shift     = 6'd0;
        in_data   = pk(-1, -2, 3, 4);
        in_valid  = 1'b1;
        tick();
        in_data = pk(40, 41, 42, 43);
        tick();
        in_valid = 1'b0;
        chk("flight out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst out_data", 64'(out_data), 64'd0);
`ifdef CNN_RELU_STATS_EN
        chk("midrst zero_cnt", 64'(zero_cnt), 64'd0);
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst idle %0d", i), 64'(out_valid), 64'd0);
        end
        one_beat("postrst", pk(9, -9, 1, -1), 2'd1, 6'd0, 0);
        chk("postrst out_valid", 64'(out_valid), 64'd1);
        chk("postrst out_data", 64'(out_data), 64'(po(9, 0, 1, 0)));
        tick();
        chk("postrst single", 64'(out_valid), 64'd0);

`ifdef CNN_RELU_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("stats clr", 64'(zero_cnt), 64'd0);
        mode     = 2'd1;
        shift    = 6'd0;
        in_data  = pk(-1, 2, -3, 4);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk("stats count", 64'(zero_cnt), 64'd6);
        stats_clr = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk("stats clr beat ready", 64'(in_ready), 64'd1);
        tick();
        stats_clr = 1'b0;
        in_valid  = 1'b0;
        chk("stats clr priority", 64'(zero_cnt), 64'd0);
        repeat (3) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_relu_stream.md
CNN_RELU_STREAM -- requirements
Module: cnn_relu_stream

Interface
REQ-001 SHALL have parameter N_CH, default 64, number of channels processed per beat.
REQ-002 SHALL have parameter IN_W, default 48, signed input width per channel.
REQ-003 SHALL have parameter OUT_W, default 16, signed output width per channel; legal range is 2 to IN_W.
REQ-004 SHALL have port clk, input, 1 bit, clock; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit, input beat valid.
REQ-007 SHALL have port in_ready, output, 1 bit, block can accept a beat.
REQ-008 SHALL have port in_data, input, N_CH*IN_W bits, signed channel i at [i*IN_W +: IN_W].
REQ-009 SHALL have port mode, input, 2 bits, activation select: 0 = bypass, 1 = ReLU, 2 = leaky (negative x>>>3), 3 = clipped ReLU.
REQ-010 SHALL have port shift, input, 6 bits, requantisation right-shift amount.
REQ-011 SHALL have port clip_max, input, IN_W bits, signed upper clip bound for mode 3.
REQ-012 SHALL have port out_valid, output, 1 bit, output beat valid.
REQ-013 SHALL have port out_ready, input, 1 bit, downstream accepts the beat.
REQ-014 SHALL have port out_data, output, N_CH*OUT_W bits, signed channel i at [i*OUT_W +: OUT_W].
REQ-015 SHALL have port out_sat, output, N_CH bits, per-channel flag set when the channel saturated.

Function
REQ-016 SHALL transfer an input beat when in_valid and in_ready are both high, and an output beat when out_valid and out_ready are both high.
REQ-017 SHALL implement a two-stage pipeline: S1 registers the activation result, S2 registers the shifted and saturated result; latency from input handshake to out_valid is 2 cycles with no stall.
REQ-018 SHALL define s1_adv = !s2_v || out_ready and in_ready = !rst && (!s1_v || s1_adv), giving full throughput of 1 beat per cycle.
REQ-019 SHALL hold out_data, out_sat and out_valid stable while out_valid=1 and out_ready=0; no beat is dropped or duplicated.
REQ-020 SHALL capture mode, shift and clip_max with each accepted beat; a change affects only beats accepted afterwards.
REQ-021 SHALL compute activation per channel as follows: mode 0 gives y=x; mode 1 gives y=max(x,0); mode 2 gives y=x for x>=0, else x>>>3 (arithmetic); mode 3 gives y=min(max(x,0),C), where C=max(clip_max,0).
REQ-022 SHALL compute r=(y+2^(shift-1))>>>shift at IN_W+1 bits with round-half-up, or r=y when shift=0; a shift value of IN_W or more SHALL be treated as IN_W-1.
REQ-023 SHALL saturate r to signed OUT_W: values above 2^(OUT_W-1)-1 go to the maximum, values below -2^(OUT_W-1) go to the minimum, and the corresponding out_sat bit SHALL be set to 1, otherwise 0.
REQ-024 SHALL make out_valid and in_ready independent of in_valid combinationally; in_ready MAY depend on out_ready.

Reset
REQ-025 SHALL clear s1_v and s2_v, zero out_data and out_sat, and drive out_valid=0 and in_ready=0 during the cycle rst is high.
REQ-026 SHALL discard in-flight beats on reset mid-operation; the first beat after reset SHALL appear 2 cycles after its handshake.

Configuration
REQ-027 SHALL, when macro CNN_RELU_STATS_EN is defined, add input stats_clr (1 bit) and output zero_cnt (32 bits), which counts channels whose activation output is 0 while the input was negative, summed per accepted beat and saturating at 2^32-1.
REQ-028 SHALL clear zero_cnt on rst or stats_clr, with stats_clr taking priority over a same-cycle increment.
REQ-029 SHALL, without CNN_RELU_STATS_EN, omit stats_clr, zero_cnt and the counting logic entirely.

Verification (N_CH=4, IN_W=48, OUT_W=16)
REQ-030 SHALL cover: mode=1, shift=0, in={-5,7,0,-1}, out_ready=1 -> 2 cycles later out={0,7,0,0}, out_sat=0.
REQ-031 SHALL cover: mode=2, shift=0, in={-64,-1,8,100000} -> out={-8,-1,8,32767}, out_sat=4'b1000.
REQ-032 SHALL cover: mode=3, clip_max=50, shift=1, in={-3,49,51,200} -> out={0,25,25,25}; with shift=1, 49 rounds to 25.
REQ-033 SHALL cover: 10 back-to-back beats with out_ready low for cycles 3-6 -> out_data held stable, in_ready=0 after 2 beats buffered, all 10 outputs delivered in order.
REQ-034 SHALL cover: rst asserted with 2 beats in flight -> out_valid=0 on the next cycle, no stale beat delivered, zero_cnt=0.
REQ-035 SHALL cover: with CNN_RELU_STATS_EN, mode=1, 3 beats each with 2 negative channels -> zero_cnt=6; stats_clr and an accepted beat in the same cycle -> zero_cnt=0.
